// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Read-side client of the register file in the multi-cycle RISC-V core.
// Captures decoded rs1/rs2/rd fields, drives the register-file read addresses,
// tracks in-flight destinations in a scoreboard, stalls on read-after-write
// hazards and hands one operand packet to execute over a valid/ready handshake.
// Only one instruction is held in the block at a time.
//
// Build option:
//   OPERAND_FETCH_FWD_EN  when defined, a busy source whose writeback commits in
//                         the same cycle is taken straight from wb_data (no
//                         stall). When undefined, the source stalls until its
//                         scoreboard bit clears and is then read from the
//                         register file on the following cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid / in_ready          decoded-field handshake (accepted in IDLE only)
//   in_rs1, in_rs2, in_rd        source / destination indices
//   in_rd_wen                    instruction writes rd
//   rf_rd_addr_1/2               register-file read addresses (captured rs1/rs2)
//   rf_rd_data_1/2               combinational register-file read data
//   wb_valid, wb_addr, wb_data   writeback commit (register file written at edge)
//   out_valid / out_ready        operand packet handshake to execute
//   out_op1, out_op2             operands
//   out_rd, out_rd_wen           destination passed through
//   stall_cnt                    saturating count of hazard stall cycles
// -----------------------------------------------------------------------------
module operand_fetch #(
   parameter int ADDRESS_LEN = 5,
   parameter int N           = 64,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDRESS_LEN-1:0] in_rs1,
   input  logic [ADDRESS_LEN-1:0] in_rs2,
   input  logic [ADDRESS_LEN-1:0] in_rd,
   input  logic                   in_rd_wen,
   output logic [ADDRESS_LEN-1:0] rf_rd_addr_1,
   output logic [ADDRESS_LEN-1:0] rf_rd_addr_2,
   input  logic [N-1:0]           rf_rd_data_1,
   input  logic [N-1:0]           rf_rd_data_2,
   input  logic                   wb_valid,
   input  logic [ADDRESS_LEN-1:0] wb_addr,
   input  logic [N-1:0]           wb_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [N-1:0]           out_op1,
   output logic [N-1:0]           out_op2,
   output logic [ADDRESS_LEN-1:0] out_rd,
   output logic                   out_rd_wen,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   localparam int NREG = 1 << ADDRESS_LEN;

`ifdef OPERAND_FETCH_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   // Stall counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + STALL_CNT_W'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // State and storage
   // ---------------------------------------------------------------------------
   state_t                 state_q, state_d;

   logic [ADDRESS_LEN-1:0] rs1_q, rs1_d;
   logic [ADDRESS_LEN-1:0] rs2_q, rs2_d;
   logic [ADDRESS_LEN-1:0] rd_q, rd_d;
   logic                   rd_wen_q, rd_wen_d;

   logic [NREG-1:0]        sb_q, sb_d;

   logic [N-1:0]           op1_q, op1_d;
   logic [N-1:0]           op2_q, op2_d;
   logic [ADDRESS_LEN-1:0] out_rd_q, out_rd_d;
   logic                   out_rd_wen_q, out_rd_wen_d;

   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   // Control strobes produced by the output process.
   logic                   capture_en;
   logic                   latch_en;
   logic                   stall_en;

   // ---------------------------------------------------------------------------
   // Hazard detection and operand selection
   // ---------------------------------------------------------------------------
   logic                   src1_fwd, src2_fwd;
   logic                   src1_haz, src2_haz;
   logic                   hazard;
   logic [N-1:0]           op1_sel, op2_sel;

   always_comb begin
      // A forward only applies to a real source whose writeback is committing
      // right now; FWD_EN folds this away entirely in the non-forwarding build.
      src1_fwd = FWD_EN && wb_valid && (wb_addr == rs1_q) && (rs1_q != '0);
      src2_fwd = FWD_EN && wb_valid && (wb_addr == rs2_q) && (rs2_q != '0);

      src1_haz = (rs1_q != '0) && sb_q[rs1_q] && !src1_fwd;
      src2_haz = (rs2_q != '0) && sb_q[rs2_q] && !src2_fwd;
      hazard   = src1_haz || src2_haz;

      // x0 reads as zero regardless of what the register file returns.
      op1_sel = '0;
      if (rs1_q != '0) begin
         op1_sel = src1_fwd ? wb_data : rf_rd_data_1;
      end
      op2_sel = '0;
      if (rs2_q != '0) begin
         op2_sel = src2_fwd ? wb_data : rf_rd_data_2;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!hazard) begin
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and control strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      capture_en = 1'b0;
      latch_en   = 1'b0;
      stall_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready   = 1'b1;
            capture_en = in_valid;
         end
         S_CHECK: begin
            latch_en = !hazard;
            stall_en = hazard;
         end
         S_OUT: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath and scoreboard next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rd_d         = rd_q;
      rd_wen_d     = rd_wen_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      out_rd_d     = out_rd_q;
      out_rd_wen_d = out_rd_wen_q;
      stall_d      = stall_q;
      sb_d         = sb_q;

      if (capture_en) begin
         rs1_d    = in_rs1;
         rs2_d    = in_rs2;
         rd_d     = in_rd;
         rd_wen_d = in_rd_wen;
      end

      if (latch_en) begin
         op1_d        = op1_sel;
         op2_d        = op2_sel;
         out_rd_d     = rd_q;
         out_rd_wen_d = rd_wen_q;
      end

      if (stall_en) begin
         stall_d = sat_inc(stall_q);
      end

      // Clear first, then set: a new producer issued on the same edge as the
      // old producer's writeback must keep the register busy.
      if (wb_valid && (wb_addr != '0)) begin
         sb_d[wb_addr] = 1'b0;
      end
      if (latch_en && rd_wen_q && (rd_q != '0)) begin
         sb_d[rd_q] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rs1_q        <= '0;
         rs2_q        <= '0;
         rd_q         <= '0;
         rd_wen_q     <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         out_rd_q     <= '0;
         out_rd_wen_q <= 1'b0;
         stall_q      <= '0;
         sb_q         <= '0;
      end else begin
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rd_q         <= rd_d;
         rd_wen_q     <= rd_wen_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         out_rd_q     <= out_rd_d;
         out_rd_wen_q <= out_rd_wen_d;
         stall_q      <= stall_d;
         sb_q         <= sb_d;
      end
   end

   assign rf_rd_addr_1 = rs1_q;
   assign rf_rd_addr_2 = rs2_q;
   assign out_op1      = op1_q;
   assign out_op2      = op2_q;
   assign out_rd       = out_rd_q;
   assign out_rd_wen   = out_rd_wen_q;
   assign stall_cnt    = stall_q;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side client of the register file in the multi-cycle RISC-V core. Accepts decoded source/destination fields, drives the register-file read addresses and captures both operands.
- Tracks in-flight destination registers with a scoreboard and stalls on read-after-write hazards.
- Hands a single operand packet to the execute stage through a valid/ready handshake.

Parameters:
- ADDRESS_LEN, 5, register address width (2**ADDRESS_LEN registers).
- N, 64, data width.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  decoded instruction fields valid
- in_ready  output  1  block can accept fields
- in_rs1  input  ADDRESS_LEN  source 1 index
- in_rs2  input  ADDRESS_LEN  source 2 index
- in_rd  input  ADDRESS_LEN  destination index
- in_rd_wen  input  1  instruction writes rd
- rf_rd_addr_1  output  ADDRESS_LEN  to register file read port 1
- rf_rd_addr_2  output  ADDRESS_LEN  to register file read port 2
- rf_rd_data_1  input  N  combinational read data port 1
- rf_rd_data_2  input  N  combinational read data port 2
- wb_valid  input  1  writeback commits this cycle (register file written at this edge)
- wb_addr  input  ADDRESS_LEN  writeback destination
- wb_data  input  N  writeback value
- out_valid  output  1  operand packet valid
- out_ready  input  1  execute stage accepts packet
- out_op1  output  N  operand 1
- out_op2  output  N  operand 2
- out_rd  output  ADDRESS_LEN  destination passed through
- out_rd_wen  output  1  destination write enable passed through
- stall_cnt  output  STALL_CNT_W  hazard stall cycles, saturating

Behaviour:
- Reset (rst low, async): state IDLE; scoreboard all 0; captured fields 0; out_op1/out_op2/out_rd/out_rd_wen 0; out_valid 0; in_ready 1; stall_cnt 0. Reset mid-operation discards the in-flight packet.
- rf_rd_addr_1/2 are always driven from the captured rs1/rs2 registers (0 after reset).
- State IDLE:
  - in_ready=1.
  - On in_valid: capture rs1, rs2, rd, rd_wen; go to CHECK.
- State CHECK:
  - in_ready=0.
  - Source s is hazardous if s!=0, scoreboard[s]=1, and s is not resolved by a forward.
  - Any hazard: stay in CHECK; stall_cnt+1, saturating at all-ones.
  - No hazard: latch out_op1/out_op2. Source 0 always yields 0, ignoring rf data. Otherwise the value is the forwarded wb_data or rf_rd_data. Latch out_rd/out_rd_wen. If rd_wen=1 and rd!=0, set scoreboard[rd]. Go to OUT.
  - Latency with no hazard: fields accepted at edge k, out_valid high after edge k+1.
- State OUT:
  - out_valid=1; outputs held stable until out_ready=1.
  - On out_valid & out_ready: go to IDLE, out_valid=0.
- Scoreboard clear: wb_valid clears scoreboard[wb_addr] at the edge, in any state.
  - Set and clear of the same index at one edge: set wins (new producer).
  - Clear of an index that is not busy: no effect.
  - wb_addr=0: ignored.
- Only one instruction is in the block at a time. in_valid is ignored outside IDLE.

Optional Feature:
- Macro OPERAND_FETCH_FWD_EN.
- Defined: in CHECK, a busy source s with wb_valid=1 and wb_addr==s is not a hazard; its operand is wb_data, taken the same cycle. Zero hazard-resolution penalty.
- Undefined: no forwarding. A busy source stalls until the scoreboard bit clears. The operand is then read from the register file the following cycle, a 1-cycle penalty.
- Scoreboard and x0 rules are identical in both builds.

Test Plan:
- Register file fresh from reset (mem[i]=i). Push rs1=5, rs2=7, rd=3, rd_wen=1; out_ready=1 -> out_valid high 2 cycles after in_valid; op1=5, op2=7, out_rd=3; scoreboard[3]=1; stall_cnt=0.
- Push rs1=0, rs2=0, rd=0, rd_wen=1 while the register file returns nonzero for index 0 -> op1=op2=0; scoreboard unchanged.
- Sequence:
  - Issue rd=3 and hold wb_valid low.
  - Push rs1=3 -> block stays in CHECK and stall_cnt increments each cycle.
  - Pulse wb_valid, wb_addr=3, wb_data=0xAB.
  - FWD_EN: op1=0xAB in the same cycle. No FWD_EN: one extra stall cycle, then op1 is taken from the register file.
- Hold out_ready=0 for 4 cycles in OUT -> outputs stable, in_ready=0, new in_valid ignored. Raise out_ready -> back to IDLE next cycle.
- At one edge, issue rd=9 and assert wb_valid with wb_addr=9 -> scoreboard[9]=1 after the edge.
- Assert rst mid-CHECK with scoreboard[3] set -> all outputs 0, in_ready=1, scoreboard clear, stall_cnt=0.
